// File: rtl/interp_filt_pkg.sv
// Shared constants and helpers for the interpolation filter blocks.
package interp_filt_pkg;

  localparam int unsigned UNDERFLOW_CNT_W = 8;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/interp_filt_upsample_if.sv
// Sample input handshake plus the zero-stuffed output stream of the upsampler.
interface interp_filt_upsample_if #(
  parameter int DATA_WIDTH = 6
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out;
  logic                         out_sop;

  modport master (
    output in_data, in_valid,
    input  in_ready, out, out_sop
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out, out_sop
  );
endinterface

// File: rtl/interp_filt_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; callers gate push/pop on count.
module interp_filt_fifo2 #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] head,
  output logic [1:0]                   count
);

  logic signed [DATA_WIDTH-1:0] mem_q [2];
  logic signed [DATA_WIDTH-1:0] mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    // Simultaneous push and pop leaves the count unchanged.
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (do_pop && !do_push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/interp_filt_upsample.sv
// Zero-stuffing front end: one buffered sample then INTERP_FACTOR-1 zeros,
// with a phase-0 strobe and sticky/counted underflow on empty phase-0 slots.
module interp_filt_upsample
  import interp_filt_pkg::*;
#(
  parameter int DATA_WIDTH    = 6,
  parameter int INTERP_FACTOR = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  interp_filt_upsample_if.slave      bus,
  output logic                       underflow,
  output logic [UNDERFLOW_CNT_W-1:0] underflow_cnt
);

  localparam int unsigned   PW     = clog2_min1(INTERP_FACTOR);
  localparam logic [PW-1:0] P_LAST = PW'(INTERP_FACTOR - 1);

  logic [PW-1:0]                p_q, p_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         sop_q, sop_d;
  logic                         uf_q, uf_d;
  logic [UNDERFLOW_CNT_W-1:0]   uf_cnt_q, uf_cnt_d;

  logic signed [DATA_WIDTH-1:0] head;
  logic [1:0]                   count;
  logic                         ready, push, pop, load;

  interp_filt_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.in_data),
    .head    (head),
    .count   (count)
  );

  always_comb begin
    ready    = (count != 2'd2);
    push     = bus.in_valid && ready;
    // p holds the phase now on out, so the last phase is the edge that loads phase 0.
    load     = (p_q == P_LAST);
    pop      = load && (count != 2'd0);
    p_d      = load ? '0 : p_q + PW'(1);
    out_d    = '0;
    sop_d    = load;
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    if (load) begin
      if (count != 2'd0) begin
        out_d = head;
      end else begin
        uf_d = 1'b1;
        if (uf_cnt_q != '1) uf_cnt_d = uf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q      <= P_LAST;
      out_q    <= '0;
      sop_q    <= 1'b0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      p_q      <= p_d;
      out_q    <= out_d;
      sop_q    <= sop_d;
      uf_q     <= uf_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out       = out_q;
  assign bus.out_sop   = sop_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule
